// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw active-low buttons in, debounced events and levels out.
interface key_conditioner_if #(
  parameter int NKEYS = 3
);
  logic [NKEYS-1:0] key_n;
  logic [NKEYS-1:0] pressed;
  logic [NKEYS-1:0] released;
  logic [NKEYS-1:0] level;

  modport master (output key_n, input pressed, input released, input level);
  modport slave  (input key_n, output pressed, output released, output level);
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer + 4-state debounce FSM producing press/release pulses and a level.
// Optional auto-repeat of pressed while held is built when KEY_AUTOREPEAT_EN is defined.
module key_conditioner #(
  parameter int NKEYS    = 3,
  parameter int DEBOUNCE = 500000,
  parameter int CNT_W    = 20,
  parameter int HOLD     = 50000000,
  parameter int REPEAT   = 10000000,
  parameter int RPT_W    = 26
) (
  input  logic              clk,
  input  logic              rst,
  key_conditioner_if.slave  kif
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [NKEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NKEYS-1:0] pressed_q, pressed_d, released_q, released_d, level_q, level_d;
  state_t           state_q [NKEYS];
  state_t           state_d [NKEYS];
  logic [CNT_W-1:0] cnt_q [NKEYS];
  logic [CNT_W-1:0] cnt_d [NKEYS];

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT - 1);

  // rphase marks that the initial HOLD delay has elapsed and REPEAT spacing applies.
  logic [RPT_W-1:0] rcnt_q [NKEYS];
  logic [RPT_W-1:0] rcnt_d [NKEYS];
  logic [NKEYS-1:0] rphase_q, rphase_d;
`else
  localparam int unused_rpt_cfg = HOLD + REPEAT + RPT_W;
`endif

  always_comb begin
    sync1_d    = ~kif.key_n;
    sync2_d    = sync1_q;
    pressed_d  = '0;
    released_d = '0;
    level_d    = '0;
`ifdef KEY_AUTOREPEAT_EN
    rphase_d   = rphase_q;
`endif
    for (int i = 0; i < NKEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef KEY_AUTOREPEAT_EN
      rcnt_d[i]  = rcnt_q[i];
`endif
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = HELD;
            pressed_d[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_d[i]    = '0;
            rphase_d[i]  = 1'b0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if ((!rphase_q[i] && rcnt_q[i] == HOLD_LAST) ||
                   ( rphase_q[i] && rcnt_q[i] == RPT_LAST)) begin
            pressed_d[i] = 1'b1;
            rcnt_d[i]    = '0;
            rphase_d[i]  = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RPT_W'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]    = IDLE;
            released_d[i] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_d[i]     = '0;
            rphase_d[i]   = 1'b0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
      level_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      level_q    <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q[i]  <= '0;
`endif
      end
`ifdef KEY_AUTOREPEAT_EN
      rphase_q   <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      level_q    <= level_d;
      for (int i = 0; i < NKEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q[i]  <= rcnt_d[i];
`endif
      end
`ifdef KEY_AUTOREPEAT_EN
      rphase_q   <= rphase_d;
`endif
    end
  end

  assign kif.pressed  = pressed_q;
  assign kif.released = released_q;
  assign kif.level    = level_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected pulse events, a monitor checks them.
module tb_key_conditioner;
  localparam int NK = 3;

  typedef struct {
    int         cyc;
    logic [2:0] p;
    logic [2:0] r;
    logic [2:0] lv;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  sb[$];

  key_conditioner_if #(.NKEYS(NK)) kif();

  key_conditioner #(
    .NKEYS(NK), .DEBOUNCE(4), .CNT_W(3), .HOLD(10), .REPEAT(5), .RPT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Any pulse must match the oldest queued event, including the cycle it lands in.
  always @(negedge clk) begin
    if (!rst && (kif.pressed != '0 || kif.released != '0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {26'd0, kif.pressed, kif.released}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pressed", {29'd0, kif.pressed}, {29'd0, e.p});
        chk("released", {29'd0, kif.released}, {29'd0, e.r});
        chk("level_at_pulse", {29'd0, kif.level}, {29'd0, e.lv});
      end
    end
  end

  initial begin
    int c;
    kif.key_n = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pressed", {29'd0, kif.pressed}, 32'd0);
    chk("rst_released", {29'd0, kif.released}, 32'd0);
    chk("rst_level", {29'd0, kif.level}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_level", {29'd0, kif.level}, 32'd0);

    // key0 press, bounce while held, then real release
    c = cyc;
    kif.key_n[0] = 1'b0;
    sb.push_back('{c + 7, 3'b001, 3'b000, 3'b001});
    repeat (8) @(negedge clk);
    chk("k0_level_held", {29'd0, kif.level}, 32'd1);
    kif.key_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    kif.key_n[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("k0_level_bounce", {29'd0, kif.level}, 32'd1);
    repeat (2) @(negedge clk);
    c = cyc;
    kif.key_n[0] = 1'b1;
    sb.push_back('{c + 7, 3'b000, 3'b001, 3'b000});
    repeat (10) @(negedge clk);
    chk("k0_level_off", {29'd0, kif.level}, 32'd0);

    // key1 short glitch rejected, then a real press
    c = cyc;
    kif.key_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    kif.key_n[1] = 1'b1;
    repeat (2) @(negedge clk);
    kif.key_n[1] = 1'b0;
    sb.push_back('{c + 12, 3'b010, 3'b000, 3'b010});
    repeat (9) @(negedge clk);
    chk("k1_level_held", {29'd0, kif.level}, 32'd2);
    c = cyc;
    kif.key_n[1] = 1'b1;
    sb.push_back('{c + 7, 3'b000, 3'b010, 3'b000});
    repeat (10) @(negedge clk);

    // all keys pressed, reset pulsed mid-debounce, keys still held afterwards
    kif.key_n = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_pressed", {29'd0, kif.pressed}, 32'd0);
    chk("midrst_level", {29'd0, kif.level}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    c = cyc;
    sb.push_back('{c + 7, 3'b111, 3'b000, 3'b111});
    repeat (9) @(negedge clk);
    chk("all_level_held", {29'd0, kif.level}, 32'd7);
    c = cyc;
    kif.key_n = '1;
    sb.push_back('{c + 7, 3'b000, 3'b111, 3'b000});
    repeat (10) @(negedge clk);

    // key2 long hold: auto-repeat pulses only when the feature is built
    c = cyc;
    kif.key_n[2] = 1'b0;
    sb.push_back('{c + 7, 3'b100, 3'b000, 3'b100});
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 0; k < 5; k++)
      sb.push_back('{c + 17 + 5 * k, 3'b100, 3'b000, 3'b100});
`endif
    repeat (35) @(negedge clk);
    kif.key_n[2] = 1'b1;
    sb.push_back('{c + 42, 3'b000, 3'b100, 3'b000});
    repeat (12) @(negedge clk);
    chk("k2_level_off", {29'd0, kif.level}, 32'd0);

    chk("missing_events", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
